// File: rtl/memblk_port_arb.sv
// memblk_port_arb
//   Shares one memblk port lane (read + write path) between NREQ requesters
//   with round-robin arbitration. Read credits bound outstanding reads per
//   requester; an LAT-deep tag pipe, advanced only on unstalled cycles,
//   records which requester issued each read so returned data can be
//   steered back with resp_id.
//
// Optional build macro: MEMBLK_ARB_STATS_EN adds grant / stall statistics.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   req_valid/we/addr/wdata   per-requester request (addr slice i = [i*AW +: AW])
//   req_ready                 one-hot grant, transfer on valid & ready
//   mb_stall                  memblk stall; freezes everything on this side
//   mb_rdaddr0/mb_rden        read launch to memblk lane
//   mb_wraddr0/mb_wrdata/mb_wren  write launch to memblk lane
//   mb_rddata/mb_rdvalid      read return from memblk lane
//   resp_valid/resp_id/resp_data  read return to requester resp_id
//   err_tag                   sticky: tag pipe / memblk valid mismatch or credit underflow
//   stat_sel, stat_grants, stat_stallcyc  (MEMBLK_ARB_STATS_EN only)
module memblk_port_arb #(
  parameter int NREQ   = 8,
  parameter int LAT    = 48,
  parameter int MAXOUT = 4,
  parameter int AW     = 39,
  parameter int DW     = 533
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ready,
  input  logic              mb_stall,
  output logic [AW-1:0]     mb_rdaddr0,
  output logic              mb_rden,
  output logic [AW-1:0]     mb_wraddr0,
  output logic [DW-1:0]     mb_wrdata,
  output logic              mb_wren,
  input  logic [DW-1:0]     mb_rddata,
  input  logic              mb_rdvalid,
  output logic              resp_valid,
  output logic [3:0]        resp_id,
  output logic [DW-1:0]     resp_data,
  output logic              err_tag
`ifdef MEMBLK_ARB_STATS_EN
  ,
  input  logic [3:0]        stat_sel,
  output logic [15:0]       stat_grants,
  output logic [15:0]       stat_stallcyc
`endif
);

  logic [3:0]      rr_ptr;
  logic [3:0]      credit [NREQ];
  logic            pipe_v [LAT];
  logic [3:0]      pipe_id [LAT];
  logic [3:0]      rd_id_q;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  logic            gnt_any;
  int              gnt_ix;
  int              ix;
  logic            acc_we;
  logic [AW-1:0]   acc_addr;
  logic [DW-1:0]   acc_wdata;
  logic            tail_v;
  logic [3:0]      tail_id;
  logic [NREQ-1:0] cred_inc;
  logic [NREQ-1:0] cred_dec;

  assign tail_v  = pipe_v[LAT-1];
  assign tail_id = pipe_id[LAT-1];

  // Round-robin search starting at rr_ptr; no grant during stall or reset.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_ix  = 0;
    ix      = 0;
    for (int i = 0; i < NREQ; i++)
      elig[i] = req_valid[i] & (req_we[i] | (credit[i] < 4'(MAXOUT)));
    if (rst && !mb_stall) begin
      for (int k = 0; k < NREQ; k++) begin
        ix = int'(rr_ptr) + k;
        if (ix >= NREQ) ix = ix - NREQ;
        if (!gnt_any && elig[ix]) begin
          grant[ix] = 1'b1;
          gnt_ix    = ix;
          gnt_any   = 1'b1;
        end
      end
    end
  end

  assign req_ready = grant;
  assign acc_we    = req_we[gnt_ix];
  assign acc_addr  = req_addr[gnt_ix*AW +: AW];
  assign acc_wdata = req_wdata[gnt_ix*DW +: DW];

  // A returning read only frees a credit on the cycle its response is
  // registered, which is the same unstalled edge as the tail leaves the pipe.
  always_comb begin
    cred_inc = '0;
    cred_dec = '0;
    for (int i = 0; i < NREQ; i++) begin
      cred_inc[i] = gnt_any && !acc_we && (gnt_ix == i);
      cred_dec[i] = !mb_stall && tail_v && (tail_id == 4'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr     <= '0;
      mb_rden    <= 1'b0;
      mb_wren    <= 1'b0;
      mb_rdaddr0 <= '0;
      mb_wraddr0 <= '0;
      mb_wrdata  <= '0;
      rd_id_q    <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      err_tag    <= 1'b0;
      for (int i = 0; i < NREQ; i++) credit[i] <= '0;
      for (int j = 0; j < LAT; j++) begin
        pipe_v[j]  <= 1'b0;
        pipe_id[j] <= '0;
      end
    end else if (mb_stall) begin
      // memblk ignores its inputs while stalled, so everything here holds.
      resp_valid <= 1'b0;
    end else begin
      mb_rden <= gnt_any & ~acc_we;
      mb_wren <= gnt_any & acc_we;
      if (gnt_any) begin
        rr_ptr <= (gnt_ix == NREQ-1) ? 4'd0 : 4'(gnt_ix + 1);
        if (acc_we) begin
          mb_wraddr0 <= acc_addr;
          mb_wrdata  <= acc_wdata;
        end else begin
          mb_rdaddr0 <= acc_addr;
          rd_id_q    <= 4'(gnt_ix);
        end
      end

      pipe_v[0]  <= mb_rden;
      pipe_id[0] <= rd_id_q;
      for (int j = 1; j < LAT; j++) begin
        pipe_v[j]  <= pipe_v[j-1];
        pipe_id[j] <= pipe_id[j-1];
      end

      resp_valid <= tail_v;
      if (tail_v) begin
        resp_id   <= tail_id;
        resp_data <= mb_rddata;
      end
      if (tail_v != mb_rdvalid) err_tag <= 1'b1;

      for (int i = 0; i < NREQ; i++) begin
        case ({cred_inc[i], cred_dec[i]})
          2'b10: if (credit[i] != 4'hF) credit[i] <= credit[i] + 4'd1;
          2'b01: begin
            if (credit[i] == 4'd0) err_tag <= 1'b1;
            else credit[i] <= credit[i] - 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MEMBLK_ARB_STATS_EN
  logic [15:0] grant_cnt [NREQ];
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
    end else begin
      if (|req_valid && mb_stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      for (int i = 0; i < NREQ; i++)
        if (gnt_any && gnt_ix == i && grant_cnt[i] != 16'hFFFF)
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
    end
  end

  assign stat_grants   = (int'(stat_sel) < NREQ) ? grant_cnt[int'(stat_sel)] : 16'd0;
  assign stat_stallcyc = stall_cnt;
`endif

endmodule

// File: doc/memblk_port_arb.md
Name: memblk_port_arb

Overview:
- Shares one memblk port lane (read and write path) between NREQ requesters using a round-robin policy.
- Holds per-requester read credits and tags each read with its requester id in a LAT-deep pipe that advances only on unstalled cycles.
- Steers returned rddata back to the requester that issued the read.
- Sits between core/L2 request queues and one index k of memblk's 36 port lanes; one instance per lane.

Parameters:
- NREQ, 8, number of requesters (2..16).
- LAT, 48, unstalled cycles from memblk rden_in sample to rden_out.
- MAXOUT, 4, max outstanding reads per requester (1..15).
- AW, 39, address width, matches memblk rdaddr0/wraddr0.
- DW, 533, data width, matches memblk rddata/wrdata (8*66+5).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  request present.
- req_we  in  NREQ  1=write, 0=read.
- req_addr  in  NREQ*AW  per-requester address; slice i = bits [i*AW +: AW].
- req_wdata  in  NREQ*DW  per-requester write data.
- req_ready  out  NREQ  one-hot grant; transfer occurs when valid&ready.
- mb_stall  in  1  memblk stall.
- mb_rdaddr0  out  AW  to memblk rdaddr0[k].
- mb_rden  out  1  to memblk rden_in[k].
- mb_wraddr0  out  AW  to memblk wraddr0[k].
- mb_wrdata  out  DW  to memblk wrdata[k].
- mb_wren  out  1  to memblk wren_in[k].
- mb_rddata  in  DW  from memblk rddata[k].
- mb_rdvalid  in  1  from memblk rden_out[k].
- resp_valid  out  1  read data return.
- resp_id  out  4  requester index of the return.
- resp_data  out  DW  returned data.
- err_tag  out  1  sticky; pipe/memblk valid mismatch.

Behaviour:
- Reset (rst=0, async): mb_rden=0, mb_wren=0, mb_rdaddr0/mb_wraddr0/mb_wrdata=0, resp_valid=0, resp_id=0, resp_data=0, err_tag=0, rr pointer=0, all credits=0, tag pipe cleared. req_ready is 0 while rst=0.
- Eligibility: requester i is eligible if req_valid[i] and (req_we[i] or credit[i]<MAXOUT).
- Grant (combinational): req_ready is one-hot over eligible requesters, searching from rr_ptr upward with wrap. It is all-zero when mb_stall=1.
- Pointer update: on an accepted transfer by requester g, rr_ptr <= (g+1) mod NREQ. Otherwise it is unchanged.
- Launch: a transfer accepted in cycle T is registered onto the mb_* outputs at T+1.
  - Read: mb_rden=1, mb_rdaddr0=addr, mb_wren=0.
  - Write: mb_wren=1, mb_wraddr0=addr, mb_wrdata=data, mb_rden=0.
  - No accept and no stall: both enables drop to 0 next cycle.
- Stall: while mb_stall=1, all mb_* outputs hold their values, no grant is issued, and the tag pipe and credits are frozen. This matches memblk, which samples inputs only on !stall.
- Tag pipe: LAT entries of {valid, id[3:0]}. Entry 0 loads {mb_rden, read id} on each unstalled cycle, and all entries shift by one on each unstalled cycle.
- Response: resp_valid/resp_id are registered from the pipe tail on an unstalled cycle. resp_data is registered from mb_rddata in the same cycle. During stall, resp_valid=0.
- Mismatch check: if the tail valid differs from mb_rdvalid on an unstalled cycle, err_tag is set. err_tag clears only on reset.
- Credits: credit[i] increments on an accepted read by i and decrements when resp_valid issues for id i. If both happen in the same cycle, the credit is unchanged. A credit never wraps; a decrement at 0 also sets err_tag.
- Writes consume no credit and produce no response.
- Mid-operation reset drops all in-flight reads silently, with no responses emitted.

Optional Feature:
- Macro: MEMBLK_ARB_STATS_EN.
- When defined, adds input stat_sel[3:0] and outputs stat_grants[15:0] and stat_stallcyc[15:0]:
  - stat_grants: per-requester saturating 16-bit grant counter for requester stat_sel.
  - stat_stallcyc: saturating 16-bit count of cycles where a request was valid but mb_stall=1.
  - Counters reset to 0 and stick at 16'hFFFF.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single read: req 2 reads addr 0x1234 at T with no stall -> mb_rden=1 and mb_rdaddr0=0x1234 at T+1; resp_valid=1 with resp_id=2 at T+1+LAT+1; credit[2] back to 0.
- Round robin: reqs 0, 3, 5 continuously valid (reads, MAXOUT large enough) -> grant order 0,3,5,0,3,5; rr_ptr wraps correctly.
- Credit limit: MAXOUT=4, req 1 issues 5 back-to-back reads -> 4 accepted and 5th ready=0 until the first response; a write from req 1 is still granted meanwhile.
- Stall: assert mb_stall for 7 cycles at T+10 after a read -> mb_* outputs held, no grants; response arrives at T+1+LAT+1+7.
- Simultaneous: req 4 read accept in the same cycle as its own earlier response -> credit[4] unchanged; err_tag stays 0.
- Reset mid-flight: 3 reads outstanding, pulse rst low -> all outputs 0 asynchronously; no resp_valid after release; credits 0.
